// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: bubble encoding, stage payload widths
// and the decode-to-execute payload packing helper.
package pipe_pkg;

   localparam logic [31:0] BUBBLE_NOP = 32'h0000_0000;

   localparam int FD_PAYLOAD_W = 64;
   localparam int DE_PAYLOAD_W = 160;
   localparam int EM_PAYLOAD_W = 128;
   localparam int MW_PAYLOAD_W = 96;

   typedef enum logic [1:0] {
      STG_FD,
      STG_DE,
      STG_EM,
      STG_MW
   } pipe_stage_e;

   function automatic logic [DE_PAYLOAD_W-1:0] pipe_pack_de(
      input logic [31:0] instr,
      input logic [31:0] pc8,
      input logic [31:0] rs,
      input logic [31:0] rt,
      input logic [31:0] ext
   );
      return {instr, pc8, rs, rt, ext};
   endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline storage slot: a valid bit plus payload that reverts
// to the bubble encoding whenever it is cleared or reset.
module pipe_slot
   import pipe_pkg::*;
#(
   parameter int               WIDTH  = DE_PAYLOAD_W,
   parameter logic [WIDTH-1:0] BUBBLE = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             clear,
   input  logic [WIDTH-1:0] d,
   output logic             valid,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         valid <= 1'b0;
         q     <= BUBBLE;
      end else if (load) begin
         valid <= 1'b1;
         q     <= d;
      end
   end

endmodule

// File: rtl/pipe_skid_reg.sv
// Elastic valid/ready pipeline register with optional skid entry,
// flush-to-bubble and a saturating stall-cycle counter.
module pipe_skid_reg
   import pipe_pkg::*;
#(
   parameter int               WIDTH  = DE_PAYLOAD_W,
   parameter logic [WIDTH-1:0] BUBBLE = '0,
   parameter bit               SKID   = 1'b1,
   parameter int               CNT_W  = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy,
   output logic [CNT_W-1:0] stall_cycles
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             h_v;
   logic [WIDTH-1:0] h_q;
   logic [WIDTH-1:0] h_d;
   logic             h_load;
   logic             h_clear;
   logic             s_v;
   logic             push;
   logic             pop;

   assign push = in_valid && in_ready;
   assign pop  = h_v && out_ready;

   pipe_slot #(
      .WIDTH  (WIDTH),
      .BUBBLE (BUBBLE)
   ) u_head (
      .clk   (clk),
      .reset (reset),
      .load  (h_load),
      .clear (h_clear),
      .d     (h_d),
      .valid (h_v),
      .q     (h_q)
   );

   generate
      if (SKID) begin : g_skid
         logic             s_load;
         logic             s_clear;
         logic [WIDTH-1:0] s_q;

         pipe_slot #(
            .WIDTH  (WIDTH),
            .BUBBLE (BUBBLE)
         ) u_skid (
            .clk   (clk),
            .reset (reset),
            .load  (s_load),
            .clear (s_clear),
            .d     (in_data),
            .valid (s_v),
            .q     (s_q)
         );

         // Registered ready: only the skid occupancy gates upstream.
         assign in_ready = !s_v;

         always_comb begin
            h_load  = 1'b0;
            h_clear = 1'b0;
            h_d     = in_data;
            s_load  = 1'b0;
            s_clear = 1'b0;
            if (flush) begin
               h_clear = 1'b1;
               s_clear = 1'b1;
            end else if (!h_v) begin
               h_load = push;
            end else if (pop) begin
               if (s_v) begin
                  h_load  = 1'b1;
                  h_d     = s_q;
                  s_clear = 1'b1;
               end else if (push) begin
                  h_load = 1'b1;
               end else begin
                  h_clear = 1'b1;
               end
            end else begin
               s_load = push;
            end
         end
      end else begin : g_single
         assign s_v      = 1'b0;
         assign in_ready = !h_v || out_ready;

         always_comb begin
            h_load  = 1'b0;
            h_clear = 1'b0;
            h_d     = in_data;
            if (flush) begin
               h_clear = 1'b1;
            end else if (push) begin
               h_load = 1'b1;
            end else if (pop) begin
               h_clear = 1'b1;
            end
         end
      end
   endgenerate

   assign out_valid = h_v;
   assign out_data  = h_q;
   assign occupancy = {1'b0, h_v} + {1'b0, s_v};

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles <= '0;
      end else if (h_v && !out_ready && stall_cycles != CNT_MAX) begin
         stall_cycles <= stall_cycles + CNT_ONE;
      end
   end

endmodule
